timer_multi_ch: RTL
===================

Name: timer_multi_ch

Overview:
- Multi-channel programmable down-counter timer; parametrised successor of the single-channel clock divider.
- NumCh independent channels share one clock and one count-enable strobe.
- Each channel has its own reload value, start/stop control, and one-shot or periodic mode.
- Drives acquisition sequencing, e.g. DAC settle, ADC conversion wait and TX pacing, from one block instead of several dividers.

Parameters:
- Width, 16, counter and reload width in bits per channel.
- NumCh, 4, number of independent channels (1..16).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- h_i  in  1  shared count-enable strobe; counters move only in cycles where h_i=1.
- start_i  in  NumCh  per-channel start/restart pulse, sampled each edge.
- stop_i  in  NumCh  per-channel abort pulse.
- mode_i  in  NumCh  per-channel mode: 0 = one-shot, 1 = periodic; sampled at expiry.
- kmax_i  in  NumCh*Width  packed reload values; channel n at [n*Width +: Width].
- tick_o  out  NumCh  registered one-cycle expiry pulse per channel.
- busy_o  out  NumCh  channel in RUN state.
- count_o  out  NumCh*Width  current count per channel, same packing as kmax_i.

Behaviour:
- Reset (rst_i=1 at an edge): every channel goes to IDLE; count=0, tick_o=0, busy_o=0. rst_i overrides all other inputs. Reset mid-count aborts with no tick.
- Channels are fully independent. Channel n is described below; all use identical logic.
- States: IDLE, RUN. busy_o = (state==RUN), registered.
- Per-edge priority, highest first:
  1. rst_i.
  2. stop_i[n]: go to IDLE, count=0, no tick.
  3. start_i[n]: count = kmax_i[n], go to RUN, no tick. Applies in IDLE or RUN; start in RUN is a restart.
  4. RUN with h_i=1 and count!=0: count = count-1.
  5. RUN with h_i=1 and count==0 (expiry): tick_o[n]=1 for the next cycle.
     - mode_i[n]=1: count = kmax_i[n] as currently presented, stay in RUN.
     - mode_i[n]=0: go to IDLE, count stays 0.
  6. Otherwise hold.
- tick_o[n] is 0 in every cycle that does not follow an expiry edge.
- Timing with h_i tied high: start at edge 0 with kmax=K gives expiry at edge K+1. tick_o is high during the cycle after edge K+1. Period is K+1 clocks, matching the legacy divider's kmax+1 division.
- With a gated h_i, the period is K+1 enabled cycles.
- kmax=0: expiry on the first enabled edge after start. In periodic mode this gives a tick every enabled cycle, so tick_o can stay high continuously when h_i=1.
- kmax_i is sampled only at start or periodic reload. Changes mid-count do not affect the current period.
- Simultaneous start and expiry on one edge: start wins. Count reloads and no tick is produced.
- Simultaneous stop and start: stop wins.
- stop_i or start_i take effect regardless of h_i.
- In IDLE, h_i has no effect.
- Count arithmetic is unsigned, Width bits. Decrement never wraps because the zero case is always handled by expiry.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: drive random start/kmax with rst_i=1 for 3 edges -> tick_o=0, busy_o=0, count_o=0 throughout; release -> still IDLE.
- One-shot: ch0 kmax=5, mode=0, h_i=1, start pulse at edge 0 -> count_o[0] shows 5,4,3,2,1,0. tick_o[0] is high exactly one cycle after edge 6. busy_o[0] drops at the same edge. No further ticks.
- Periodic plus gating: ch1 kmax=3, mode=1, h_i high every other cycle -> tick every 8 clocks (4 enabled cycles). Change kmax to 1 mid-period -> current period still 8; next period 4 clocks.
- Restart and priority: ch2 kmax=10 running at count=4, assert start -> count reloads to 10, no tick. Start and stop together -> IDLE, count 0. Start on the exact expiry edge -> no tick, count=kmax.
- Edge values: ch3 kmax=0 periodic, h_i=1 -> tick_o[3] continuously high. kmax=2^Width-1 one-shot -> single tick after 2^Width cycles.
- Independence: all NumCh=4 channels started on the same edge with kmax=2,5,7,0 and mixed modes -> each matches a per-channel reference model. Stop on ch1 does not disturb ch0, ch2 or ch3.

Source files
------------

// File: rtl/timer_multi_ch_if.sv
// Control and status bundle for the multi-channel timer.
// Master drives control, slave (the timer) returns status.
interface timer_multi_ch_if #(
  parameter int Width = 16,
  parameter int NumCh = 4
);
  logic                   h_i;
  logic [NumCh-1:0]       start_i;
  logic [NumCh-1:0]       stop_i;
  logic [NumCh-1:0]       mode_i;
  logic [NumCh*Width-1:0] kmax_i;
  logic [NumCh-1:0]       tick_o;
  logic [NumCh-1:0]       busy_o;
  logic [NumCh*Width-1:0] count_o;

  modport master (
    output h_i, start_i, stop_i, mode_i, kmax_i,
    input  tick_o, busy_o, count_o
  );

  modport slave (
    input  h_i, start_i, stop_i, mode_i, kmax_i,
    output tick_o, busy_o, count_o
  );
endinterface

// File: rtl/timer_multi_ch.sv
// Multi-channel programmable down-counter timer.
// Shared count-enable strobe; per-channel one-shot or periodic reload.
module timer_multi_ch #(
  parameter int Width = 16,
  parameter int NumCh = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  timer_multi_ch_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           st_q  [NumCh];
  state_e           st_d  [NumCh];
  logic [Width-1:0] cnt_q [NumCh];
  logic [Width-1:0] cnt_d [NumCh];
  logic [NumCh-1:0] tick_q;
  logic [NumCh-1:0] tick_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NumCh; n++) begin
        st_q[n]  <= IDLE;
        cnt_q[n] <= '0;
      end
      tick_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Stop beats start, start beats expiry.
  always_comb begin
    tick_d = '0;
    for (int n = 0; n < NumCh; n++) begin
      st_d[n]  = st_q[n];
      cnt_d[n] = cnt_q[n];
      if (bus.stop_i[n]) begin
        st_d[n]  = IDLE;
        cnt_d[n] = '0;
      end else if (bus.start_i[n]) begin
        st_d[n]  = RUN;
        cnt_d[n] = bus.kmax_i[n*Width +: Width];
      end else if (st_q[n] == RUN && bus.h_i) begin
        if (cnt_q[n] != '0) begin
          cnt_d[n] = cnt_q[n] - Width'(1);
        end else begin
          tick_d[n] = 1'b1;
          if (bus.mode_i[n]) begin
            cnt_d[n] = bus.kmax_i[n*Width +: Width];
          end else begin
            st_d[n] = IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    bus.tick_o  = tick_q;
    bus.busy_o  = '0;
    bus.count_o = '0;
    for (int n = 0; n < NumCh; n++) begin
      bus.busy_o[n] = (st_q[n] == RUN);
      bus.count_o[n*Width +: Width] = cnt_q[n];
    end
  end

endmodule
